// File: rtl/escalonador_requisicoes_pkg.sv
// Shared definitions for the request scheduler: state encoding, command and
// response codes, and the command-validity helper.
package escalonador_requisicoes_pkg;

    typedef logic [3:0] estado_t;

    localparam estado_t OCIOSO        = 4'd0;
    localparam estado_t ESPERA_CMD    = 4'd1;
    localparam estado_t VALIDA        = 4'd2;
    localparam estado_t SENSOR_INI    = 4'd3;
    localparam estado_t SENSOR_ESPERA = 4'd4;
    localparam estado_t DECODIFICA    = 4'd5;
    localparam estado_t AMOSTRA       = 4'd6;
    localparam estado_t TX0           = 4'd7;
    localparam estado_t TX0_ESPERA    = 4'd8;
    localparam estado_t TX1           = 4'd9;
    localparam estado_t TX1_ESPERA    = 4'd10;

    localparam logic [7:0] CMD_03 = 8'h03;
    localparam logic [7:0] CMD_04 = 8'h04;
    localparam logic [7:0] CMD_05 = 8'h05;

    localparam logic [7:0] RESP_TIMEOUT     = 8'hFD;
    localparam logic [7:0] RESP_ENDERECO    = 8'hFE;
    localparam logic [7:0] RESP_CMD_INVALID = 8'hFF;

    function automatic logic comando_valido(input logic [7:0] cmd);
        return (cmd == CMD_03) || (cmd == CMD_04) || (cmd == CMD_05);
    endfunction

endpackage

// File: rtl/escalonador_requisicoes_if.sv
// Bus between the request scheduler and its UART, sensor and decoder peers.
// The scheduler uses the slave modport; its environment uses master.
interface escalonador_requisicoes_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       sensor_start;
    logic       sensor_done;
    logic [7:0] solicitacao;
    logic [7:0] endereco;
    logic [7:0] dados;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       ocupado;

    modport slave (
        input  rx_valid, rx_data, sensor_done, dados, tx_busy,
        output sensor_start, solicitacao, endereco, tx_start, tx_data, ocupado
    );

    modport master (
        output rx_valid, rx_data, sensor_done, dados, tx_busy,
        input  sensor_start, solicitacao, endereco, tx_start, tx_data, ocupado
    );

endinterface

// File: rtl/escalonador_requisicoes_temporizador_timeout.sv
// Saturating 32-bit wait counter used for the sensor timeout
// (only instantiated when SENSOR_TIMEOUT_EN is defined).
module temporizador_timeout (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic [31:0] limit_i,
    output logic        expired_o
);

    logic [31:0] contador_q, contador_d;

    always_comb begin
        contador_d = contador_q;
        if (clear_i) begin
            contador_d = '0;
        end else if (enable_i && (contador_q != '1)) begin
            contador_d = contador_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            contador_q <= '0;
        end else begin
            contador_q <= contador_d;
        end
    end

    assign expired_o = (contador_q >= limit_i);

endmodule

// File: rtl/escalonador_requisicoes.sv
// Request scheduler: receives address + command over UART, runs a sensor
// acquisition and returns a two-byte reply. Optional: SENSOR_TIMEOUT_EN.
module escalonador_requisicoes
    import escalonador_requisicoes_pkg::*;
#(
    parameter logic [7:0]  ENDERECO_SENSOR = 8'h01,
    parameter logic [31:0] TIMEOUT_CICLOS  = 32'd100_000_000
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    escalonador_requisicoes_if.slave    bus
);

    estado_t    estado_q, estado_d;
    logic [7:0] endereco_q, endereco_d;
    logic [7:0] solicitacao_q, solicitacao_d;
    logic [7:0] resposta_q, resposta_d;
    logic [7:0] byte1_q, byte1_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       primeiro_q, primeiro_d;
    logic       expirado;

`ifdef SENSOR_TIMEOUT_EN
    temporizador_timeout u_temporizador (
        .clk_i     (clock_i),
        .rst_i     (reset_i),
        .clear_i   (estado_q == SENSOR_INI),
        .enable_i  (estado_q == SENSOR_ESPERA),
        .limit_i   (TIMEOUT_CICLOS),
        .expired_o (expirado)
    );
`else
    assign expirado = 1'b0;
`endif

    always_comb begin
        estado_d      = estado_q;
        endereco_d    = endereco_q;
        solicitacao_d = solicitacao_q;
        resposta_d    = resposta_q;
        byte1_d       = byte1_q;
        tx_data_d     = tx_data_q;
        primeiro_d    = primeiro_q;

        // tx_data is loaded on entry to TX0/TX1 so it is already valid while
        // the combinational tx_start is high in those states.
        case (estado_q)
            OCIOSO: begin
                if (bus.rx_valid) begin
                    endereco_d = bus.rx_data;
                    estado_d   = ESPERA_CMD;
                end
            end
            ESPERA_CMD: begin
                if (bus.rx_valid) begin
                    solicitacao_d = bus.rx_data;
                    estado_d      = VALIDA;
                end
            end
            VALIDA: begin
                if (endereco_q != ENDERECO_SENSOR) begin
                    resposta_d = RESP_ENDERECO;
                    byte1_d    = 8'h00;
                    tx_data_d  = RESP_ENDERECO;
                    estado_d   = TX0;
                end else if (!comando_valido(solicitacao_q)) begin
                    resposta_d = RESP_CMD_INVALID;
                    byte1_d    = 8'h00;
                    tx_data_d  = RESP_CMD_INVALID;
                    estado_d   = TX0;
                end else begin
                    estado_d = SENSOR_INI;
                end
            end
            SENSOR_INI: estado_d = SENSOR_ESPERA;
            SENSOR_ESPERA: begin
                if (bus.sensor_done) begin
                    estado_d = DECODIFICA;
                end else if (expirado) begin
                    resposta_d = RESP_TIMEOUT;
                    byte1_d    = 8'h00;
                    tx_data_d  = RESP_TIMEOUT;
                    estado_d   = TX0;
                end
            end
            DECODIFICA: estado_d = AMOSTRA;
            AMOSTRA: begin
                byte1_d    = bus.dados;
                resposta_d = solicitacao_q;
                tx_data_d  = solicitacao_q;
                estado_d   = TX0;
            end
            TX0: begin
                if (!bus.tx_busy) begin
                    primeiro_d = 1'b1;
                    estado_d   = TX0_ESPERA;
                end
            end
            TX0_ESPERA: begin
                if (primeiro_q) begin
                    primeiro_d = 1'b0;
                end else if (!bus.tx_busy) begin
                    tx_data_d = byte1_q;
                    estado_d  = TX1;
                end
            end
            TX1: begin
                if (!bus.tx_busy) begin
                    primeiro_d = 1'b1;
                    estado_d   = TX1_ESPERA;
                end
            end
            TX1_ESPERA: begin
                if (primeiro_q) begin
                    primeiro_d = 1'b0;
                end else if (!bus.tx_busy) begin
                    estado_d = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            estado_q      <= OCIOSO;
            endereco_q    <= '0;
            solicitacao_q <= '0;
            resposta_q    <= '0;
            byte1_q       <= '0;
            tx_data_q     <= '0;
            primeiro_q    <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            endereco_q    <= endereco_d;
            solicitacao_q <= solicitacao_d;
            resposta_q    <= resposta_d;
            byte1_q       <= byte1_d;
            tx_data_q     <= tx_data_d;
            primeiro_q    <= primeiro_d;
        end
    end

    // Strobes are masked by reset so nothing escapes during the reset cycle.
    assign bus.sensor_start = !reset_i && (estado_q == SENSOR_INI);
    assign bus.tx_start     = !reset_i && !bus.tx_busy
                              && ((estado_q == TX0) || (estado_q == TX1));
    assign bus.ocupado      = !reset_i && (estado_q != OCIOSO);
    assign bus.solicitacao  = solicitacao_q;
    assign bus.endereco     = endereco_q;
    assign bus.tx_data      = tx_data_q;

endmodule

// File: tb/tb_escalonador_requisicoes.sv
// Scoreboard bench for escalonador_requisicoes (build with or without
// SENSOR_TIMEOUT_EN).
module tb_escalonador_requisicoes;

`ifdef SENSOR_TIMEOUT_EN
    localparam logic [31:0] TB_TIMEOUT = 32'd20;
`else
    localparam logic [31:0] TB_TIMEOUT = 32'd100_000_000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    escalonador_requisicoes_if bus ();

    escalonador_requisicoes #(
        .ENDERECO_SENSOR (8'h01),
        .TIMEOUT_CICLOS  (TB_TIMEOUT)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         tx_count = 0;
    int         sensor_pulses = 0;
    int         exp_pulses = 0;
    logic [7:0] exp_q[$];
    int         start_cyc_q[$];
    logic [7:0] held = '0;
    bit         long_next = 0;
    bit         pend = 0;
    int         busy_cnt = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nome, atual, esperado, cyc);
        end
    endtask

    // Transmitter model: busy rises one cycle after tx_start, lasts 3 (or 50) cycles.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0;
                busy_cnt = 0;
                bus.tx_busy = 1'b0;
            end else if (pend) begin
                pend = 0;
                busy_cnt = long_next ? 50 : 3;
                long_next = 0;
                bus.tx_busy = 1'b1;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) bus.tx_busy = 1'b0;
            end
            #1;
            if (bus.tx_start) pend = 1;
        end
    end

    // Monitor: pops the expected byte on each tx_start.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (bus.tx_start) begin
                tx_count++;
                start_cyc_q.push_back(cyc);
                check("tx_start_while_busy", {31'b0, bus.tx_busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got %0h, required no transmission", bus.tx_data);
                end else begin
                    check("tx_data", {24'b0, bus.tx_data}, {24'b0, exp_q.pop_front()});
                end
                held = bus.tx_data;
            end else if (bus.tx_busy) begin
                check("tx_data_stable", {24'b0, bus.tx_data}, {24'b0, held});
            end
            if (bus.sensor_start) begin
                sensor_pulses++;
                check("start_exclusive", {31'b0, bus.tx_start}, 32'd0);
            end
        end
    end

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_sensor_start(output int c);
        bit ok = 0;
        c = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (bus.sensor_start) begin
                ok = 1;
                c = cyc;
                break;
            end
        end
        check("sensor_start_seen", {31'b0, ok}, 32'd1);
    endtask

    task automatic pulse_done(input int n);
        repeat (n) @(negedge clk);
        bus.sensor_done = 1'b1;
        @(negedge clk);
        bus.sensor_done = 1'b0;
    endtask

    task automatic wait_idle(input string nome, input int max);
        bit ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            #1;
            if (!bus.ocupado) begin
                ok = 1;
                break;
            end
        end
        check(nome, {31'b0, ok}, 32'd1);
    endtask

    task automatic check_latency(input string nome, input int s, input int lat);
        int first = (start_cyc_q.size() > 0) ? start_cyc_q[0] : s - 1;
        check(nome, first - s, lat);
    endtask

    task automatic check_outputs_reset(input string nome);
        check({nome, "_ocupado"}, {31'b0, bus.ocupado}, 32'd0);
        check({nome, "_sensor_start"}, {31'b0, bus.sensor_start}, 32'd0);
        check({nome, "_tx_start"}, {31'b0, bus.tx_start}, 32'd0);
        check({nome, "_tx_data"}, {24'b0, bus.tx_data}, 32'd0);
        check({nome, "_solicitacao"}, {24'b0, bus.solicitacao}, 32'd0);
        check({nome, "_endereco"}, {24'b0, bus.endereco}, 32'd0);
    endtask

    initial begin
        int s;
        int tx_before;
        bit ok;
        bus.rx_valid    = 1'b0;
        bus.rx_data     = '0;
        bus.sensor_done = 1'b0;
        bus.dados       = 8'h19;

        repeat (3) @(negedge clk);
        #1;
        check_outputs_reset("reset_held");
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_outputs_reset("after_reset");

        // Valid request, sensor_done 10 cycles after sensor_start
        start_cyc_q.delete();
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h19);
        send_rx(8'h01);
        send_rx(8'h04);
        wait_sensor_start(s);
        exp_pulses++;
        check("latched_endereco", {24'b0, bus.endereco}, 32'h01);
        check("latched_solicitacao", {24'b0, bus.solicitacao}, 32'h04);
        pulse_done(10);
        wait_idle("valid_idle", 200);
        check_latency("valid_latency", s, 13);
        check("valid_tx_count", tx_count, 2);
        check("valid_pulses", sensor_pulses, exp_pulses);

        // Wrong address
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'h00);
        send_rx(8'h07);
        send_rx(8'h04);
        wait_idle("addr_idle", 200);
        check("addr_no_sensor", sensor_pulses, exp_pulses);
        check("addr_tx_count", tx_count, 4);

        // Unknown command
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        send_rx(8'h01);
        send_rx(8'h09);
        wait_idle("cmd_idle", 200);
        check("cmd_no_sensor", sensor_pulses, exp_pulses);
        check("cmd_tx_count", tx_count, 6);

        // Long busy after first byte, stray rx while transmitting
        bus.dados = 8'h2A;
        long_next = 1;
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h2A);
        send_rx(8'h01);
        send_rx(8'h03);
        wait_sensor_start(s);
        exp_pulses++;
        pulse_done(2);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (tx_count == 7) begin
                ok = 1;
                break;
            end
        end
        check("busy_first_tx_seen", {31'b0, ok}, 32'd1);
        send_rx(8'h55);
        send_rx(8'h66);
        wait_idle("busy_idle", 300);
        check("busy_tx_count", tx_count, 8);
        check("busy_endereco_kept", {24'b0, bus.endereco}, 32'h01);
        check("busy_solicitacao_kept", {24'b0, bus.solicitacao}, 32'h03);
        check("busy_pulses", sensor_pulses, exp_pulses);

        // No sensor_done
        start_cyc_q.delete();
        tx_before = tx_count;
        send_rx(8'h01);
        send_rx(8'h05);
`ifdef SENSOR_TIMEOUT_EN
        exp_q.push_back(8'hFD);
        exp_q.push_back(8'h00);
        wait_sensor_start(s);
        exp_pulses++;
        wait_idle("timeout_idle", 200);
        check_latency("timeout_latency", s, 22);
        check("timeout_tx_count", tx_count, tx_before + 2);
        start_cyc_q.delete();
        send_rx(8'h01);
        send_rx(8'h04);
        wait_sensor_start(s);
        exp_pulses++;
        repeat (3) @(negedge clk);
`else
        wait_sensor_start(s);
        exp_pulses++;
        repeat (1000) @(negedge clk);
        #1;
        check("hang_no_tx", tx_count, tx_before);
        check("hang_ocupado", {31'b0, bus.ocupado}, 32'd1);
`endif

        // Reset while waiting for the sensor
        tx_before = tx_count;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_outputs_reset("mid_reset");
        rst = 1'b0;
        pulse_done(1);
        repeat (50) @(negedge clk);
        #1;
        check("reset_no_tx", tx_count, tx_before);
        check("reset_ocupado", {31'b0, bus.ocupado}, 32'd0);
        check("reset_pulses", sensor_pulses, exp_pulses);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/escalonador_requisicoes.md
ESCALONADOR_REQUISICOES -- requirements
Module: escalonador_requisicoes

Interface
REQ-001 Parameter ENDERECO_SENSOR, 8'h01, bus address this node answers to.
REQ-002 Parameter TIMEOUT_CICLOS, 32'd100_000_000, sensor_done wait limit in clock cycles (2 s at 50 MHz).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clock  in  1  system clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 rx_valid  in  1  one-cycle strobe, rx_data holds a received UART byte.
REQ-007 rx_data  in  8  received byte.
REQ-008 sensor_start  out  1  one-cycle pulse starting a sensor acquisition.
REQ-009 sensor_done  in  1  one-cycle strobe, acquisition finished, sensor bytes valid.
REQ-010 solicitacao  out  8  request code driven to the decoder.
REQ-011 endereco  out  8  latched address driven to the decoder.
REQ-012 dados  in  8  decoder result, registered (1-cycle latency).
REQ-013 tx_start  out  1  one-cycle pulse sending tx_data.
REQ-014 tx_data  out  8  byte to transmit, held stable from tx_start until tx_busy falls.
REQ-015 tx_busy  in  1  transmitter busy; rises no later than cycle after tx_start.
REQ-016 ocupado  out  1  high in every state except OCIOSO.

Function
REQ-017 FSM states: OCIOSO, ESPERA_CMD, VALIDA, SENSOR_INI, SENSOR_ESPERA, DECODIFICA, AMOSTRA, TX0, TX0_ESPERA, TX1, TX1_ESPERA.
REQ-018 OCIOSO: rx_valid latches rx_data into endereco, -> ESPERA_CMD.
REQ-019 ESPERA_CMD: rx_valid latches rx_data into solicitacao, -> VALIDA.
REQ-020 VALIDA: endereco != ENDERECO_SENSOR -> resposta 8'hFE, byte1 8'h00, -> TX0; command not in {8'h03,8'h04,8'h05} -> resposta 8'hFF, byte1 8'h00, -> TX0; else -> SENSOR_INI.
REQ-021 SENSOR_INI: sensor_start high exactly one cycle, timeout counter cleared, -> SENSOR_ESPERA.
REQ-022 SENSOR_ESPERA: sensor_done -> DECODIFICA; counter increments each cycle otherwise.
REQ-023 DECODIFICA: solicitacao held one cycle for decoder register, -> AMOSTRA.
REQ-024 AMOSTRA: byte1 <= dados, resposta <= solicitacao (echo), -> TX0.
REQ-025 TX0: when tx_busy low, tx_data <= resposta, tx_start pulse, -> TX0_ESPERA.
REQ-026 TX0_ESPERA: ignore tx_busy for the first cycle, then -> TX1 when tx_busy low; TX1/TX1_ESPERA identical with byte1, then -> OCIOSO.
REQ-027 Response latency, valid request, sensor_done at cycle N after sensor_start: first tx_start at N+3 if tx_busy low.
REQ-028 rx_valid in any state other than OCIOSO/ESPERA_CMD is dropped; no queueing.
REQ-029 Timeout counter 32-bit, saturates; never wraps.
REQ-030 sensor_done outside SENSOR_ESPERA is ignored.
REQ-031 sensor_start, tx_start never high in the same cycle.

Reset
REQ-032 reset: state OCIOSO; sensor_start, tx_start, ocupado 0; tx_data, solicitacao, endereco, resposta, byte1, counter 8'h00/0.
REQ-033 reset has priority over every event, including mid-transmission; pending transaction is abandoned, no further tx_start.

Configuration
REQ-034 Macro SENSOR_TIMEOUT_EN defined: counter reaching TIMEOUT_CICLOS in SENSOR_ESPERA -> resposta 8'hFD, byte1 8'h00, -> TX0.
REQ-035 Macro SENSOR_TIMEOUT_EN undefined: counter and timeout path absent; SENSOR_ESPERA waits indefinitely for sensor_done.

Structure
REQ-036 Shared package: state encoding, command codes 8'h03/8'h04/8'h05, response codes 8'hFD/8'hFE/8'hFF.
REQ-037 One sub-module natural: temporizador_timeout (clear, enable, limit, expired), instantiated only under SENSOR_TIMEOUT_EN.

Verification
REQ-038 rx 8'h01, 8'h04; sensor_done 10 cycles after sensor_start; dados 8'h19 -> tx 8'h04 then 8'h19, ocupado low after.
REQ-039 rx 8'h07, 8'h04 -> no sensor_start; tx 8'hFE, 8'h00.
REQ-040 rx 8'h01, 8'h09 -> no sensor_start; tx 8'hFF, 8'h00.
REQ-041 SENSOR_TIMEOUT_EN, TIMEOUT_CICLOS=20, no sensor_done -> tx 8'hFD, 8'h00 after 20 cycles; without macro -> no tx after 1000 cycles.
REQ-042 tx_busy held high 50 cycles after first tx_start -> second tx_start not before tx_busy falls; rx_valid during it ignored.
REQ-043 reset asserted in SENSOR_ESPERA -> next cycle OCIOSO, all outputs at reset values, later sensor_done produces no tx.
